// File: rtl/idss_ctrl_pkg.sv
// Shared types and constants for the IDSS sequencer.
// State encoding, CSS count and kernel geometry.
package idss_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_WINDOW,
    S_DONE
  } idss_ctrl_state_t;

  localparam int NB_CSS      = 4;
  localparam int KERNEL_SIZE = 3;
  localparam int LE_SEL_W    = 2;

endpackage

// File: rtl/idss_ctrl_if.sv
// Control/handshake bundle between IDSS sequencer and its neighbours.
// master = sequencer side, slave = upstream/PE side.
interface idss_ctrl_if
  import idss_pkg::*;
#(
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64
);
  localparam int XW = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW = $clog2(FEATURE_MAP_HEIGHT);
  localparam int GW = $clog2(INPUT_NB_CHANNELS / NB_CSS) + 1;

  logic                start;
  logic                busy;
  logic                done;
  logic                in_valid;
  logic                in_ready;
  logic                le_en;
  logic [LE_SEL_W-1:0] le_select;
  logic                shift;
  logic                win_valid;
  logic                win_ready;
  logic [XW-1:0]       win_x;
  logic [YW-1:0]       win_y;
  logic [GW-1:0]       win_cg;
`ifdef IDSS_CTRL_STALL_CNT_EN
  logic [31:0]         stall_cycles;
`endif

  modport master (
    input  start, in_valid, win_ready,
    output busy, done, in_ready, le_en, le_select,
    output shift, win_valid, win_x, win_y, win_cg
`ifdef IDSS_CTRL_STALL_CNT_EN
    , output stall_cycles
`endif
  );

  modport slave (
    output start, in_valid, win_ready,
    input  busy, done, in_ready, le_en, le_select,
    input  shift, win_valid, win_x, win_y, win_cg
`ifdef IDSS_CTRL_STALL_CNT_EN
    , input stall_cycles
`endif
  );

endinterface

// File: rtl/idss_wrap_cnt.sv
// Up-counter with clear and enable; wraps to 0 after MAX.
// wrap_o flags the terminal count so callers can chain counters.
module idss_wrap_cnt #(
  parameter int WIDTH = 2,
  parameter int MAX   = 3
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == WIDTH'(MAX));
  assign cnt_o  = cnt_q;

  // next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/idss_ctrl.sv
// IDSS sequencer: load 4 channels, shift, present 3x3x4 windows.
// Optional stall counter enabled by macro IDSS_CTRL_STALL_CNT_EN.
module idss_ctrl
  import idss_pkg::*;
#(
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64
) (
  input logic         clk,
  input logic         arst_n_in,
  idss_ctrl_if.master bus
);
  localparam int G  = INPUT_NB_CHANNELS / NB_CSS;
  localparam int XW = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW = $clog2(FEATURE_MAP_HEIGHT);
  localparam int GW = $clog2(G) + 1;
  localparam int CW = $clog2(FEATURE_MAP_WIDTH + 1);

  idss_ctrl_state_t state_q;

  logic                busy_q, done_q, in_ready_q;
  logic                shift_q, win_valid_q;
  logic [XW-1:0]       win_x_q;
  logic [YW-1:0]       win_y_q;
  logic [GW-1:0]       win_cg_q;

  logic [LE_SEL_W-1:0] ch_q;
  logic [CW-1:0]       col_q;
  logic [YW-1:0]       y_q;
  logic [GW-1:0]       cg_q;
  logic                ch_wrap, col_wrap, y_wrap, cg_wrap;

  logic idle_clr, le_en, win_acc, strip_end;

  assign idle_clr  = (state_q == S_IDLE);
  assign le_en     = bus.in_valid & in_ready_q;
  assign win_acc   = win_valid_q & bus.win_ready;
  assign strip_end = win_acc & col_wrap;

  idss_wrap_cnt #(.WIDTH(LE_SEL_W), .MAX(NB_CSS - 1)) u_ch (
    .clk(clk), .arst_n_in(arst_n_in),
    .clr_i(idle_clr), .inc_i(le_en),
    .cnt_o(ch_q), .wrap_o(ch_wrap)
  );

  idss_wrap_cnt #(.WIDTH(CW), .MAX(FEATURE_MAP_WIDTH)) u_col (
    .clk(clk), .arst_n_in(arst_n_in),
    .clr_i(idle_clr | strip_end),
    .inc_i(state_q == S_SHIFT),
    .cnt_o(col_q), .wrap_o(col_wrap)
  );

  idss_wrap_cnt #(.WIDTH(YW), .MAX(FEATURE_MAP_HEIGHT - KERNEL_SIZE)) u_y (
    .clk(clk), .arst_n_in(arst_n_in),
    .clr_i(idle_clr), .inc_i(strip_end),
    .cnt_o(y_q), .wrap_o(y_wrap)
  );

  idss_wrap_cnt #(.WIDTH(GW), .MAX(G - 1)) u_cg (
    .clk(clk), .arst_n_in(arst_n_in),
    .clr_i(idle_clr), .inc_i(strip_end & y_wrap),
    .cnt_o(cg_q), .wrap_o(cg_wrap)
  );

  // sequencer FSM with registered Moore outputs
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      shift_q     <= 1'b0;
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      win_cg_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          win_x_q  <= '0;
          win_y_q  <= '0;
          win_cg_q <= '0;
          if (bus.start) begin
            state_q    <= S_LOAD;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.in_valid && ch_wrap) begin
            state_q    <= S_SHIFT;
            in_ready_q <= 1'b0;
            shift_q    <= 1'b1;
          end
        end
        S_SHIFT: begin
          shift_q <= 1'b0;
          if (col_q >= CW'(KERNEL_SIZE - 1)) begin
            state_q     <= S_WINDOW;
            win_valid_q <= 1'b1;
            win_x_q     <= XW'(col_q - CW'(KERNEL_SIZE - 1));
            win_y_q     <= y_q;
            win_cg_q    <= cg_q;
          end else begin
            state_q    <= S_LOAD;
            in_ready_q <= 1'b1;
          end
        end
        S_WINDOW: begin
          if (bus.win_ready) begin
            win_valid_q <= 1'b0;
            if (col_wrap && y_wrap && cg_wrap) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_LOAD;
              in_ready_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.le_en     = le_en;
  assign bus.le_select = ch_q;
  assign bus.shift     = shift_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_x     = win_x_q;
  assign bus.win_y     = win_y_q;
  assign bus.win_cg    = win_cg_q;

`ifdef IDSS_CTRL_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        stall_ev;

  assign stall_ev = ((state_q == S_LOAD) & ~bus.in_valid) |
                    ((state_q == S_WINDOW) & ~bus.win_ready);

  // saturating stall counter, cleared when a pass starts
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in)
      stall_q <= '0;
    else if (idle_clr && bus.start)
      stall_q <= '0;
    else if (stall_ev && (stall_q != '1))
      stall_q <= stall_q + 1'b1;
  end

  assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_idss_ctrl.sv
// Directed bench for idss_ctrl: two configurations, stalls, reset.
// Build with IDSS_CTRL_STALL_CNT_EN to also check stall_cycles.
module tb_idss_ctrl;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic sel = 1'b0;
  logic st = 1'b0;
  logic iv = 1'b1;
  logic wr = 1'b1;

  int ntests = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  idss_ctrl_if #(
    .FEATURE_MAP_WIDTH(5), .FEATURE_MAP_HEIGHT(3),
    .INPUT_NB_CHANNELS(4)
  ) ifa ();

  idss_ctrl_if #(
    .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(4),
    .INPUT_NB_CHANNELS(8)
  ) ifb ();

  assign ifa.start     = st & ~sel;
  assign ifa.in_valid  = iv;
  assign ifa.win_ready = wr;
  assign ifb.start     = st & sel;
  assign ifb.in_valid  = iv;
  assign ifb.win_ready = wr;

  idss_ctrl #(
    .FEATURE_MAP_WIDTH(5), .FEATURE_MAP_HEIGHT(3),
    .INPUT_NB_CHANNELS(4)
  ) u_a (
    .clk(clk), .arst_n_in(arst_n), .bus(ifa.master)
  );

  idss_ctrl #(
    .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(4),
    .INPUT_NB_CHANNELS(8)
  ) u_b (
    .clk(clk), .arst_n_in(arst_n), .bus(ifb.master)
  );

  logic       o_busy, o_done, o_ir, o_le, o_sh, o_wv;
  logic [1:0] o_sel;
  logic [7:0] o_x, o_y, o_g;

  always_comb begin
    o_busy = sel ? ifb.busy      : ifa.busy;
    o_done = sel ? ifb.done      : ifa.done;
    o_ir   = sel ? ifb.in_ready  : ifa.in_ready;
    o_le   = sel ? ifb.le_en     : ifa.le_en;
    o_sh   = sel ? ifb.shift     : ifa.shift;
    o_wv   = sel ? ifb.win_valid : ifa.win_valid;
    o_sel  = sel ? ifb.le_select : ifa.le_select;
    o_x    = sel ? 8'(ifb.win_x) : 8'(ifa.win_x);
    o_y    = sel ? 8'(ifb.win_y) : 8'(ifa.win_y);
    o_g    = sel ? 8'(ifb.win_cg) : 8'(ifa.win_cg);
  end

  int acc_c[$];
  int acc_x[$];
  int acc_y[$];
  int acc_g[$];
  int le_n, sel_bad, overlap, done_c, done_n;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_in_ready"}, o_ir, 0);
    chk({tag, "_le_en"}, o_le, 0);
    chk({tag, "_le_select"}, o_sel, 0);
    chk({tag, "_shift"}, o_sh, 0);
    chk({tag, "_win_valid"}, o_wv, 0);
    chk({tag, "_win_x"}, o_x, 0);
    chk({tag, "_win_y"}, o_y, 0);
    chk({tag, "_win_cg"}, o_g, 0);
  endtask

  // start at edge 0; cycle c lies between edge c-1 and edge c
  task automatic run(input bit s, input int n,
                     input int iv_a, input int iv_b,
                     input int wr_a, input int wr_b,
                     input int st2);
    sel = s;
    acc_c.delete(); acc_x.delete();
    acc_y.delete(); acc_g.delete();
    le_n = 0; sel_bad = 0; overlap = 0;
    done_c = -1; done_n = 0;
    @(negedge clk);
    st = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      st = (c == st2);
      iv = !(c >= iv_a && c <= iv_b);
      wr = !(c >= wr_a && c <= wr_b);
      @(negedge clk);
      if (o_le) begin
        if (o_sel != 2'(le_n % 4)) sel_bad++;
        le_n++;
      end
      if (o_le && o_sh) overlap++;
      if (c >= iv_a && c <= iv_b) begin
        chk("ivstall_le_en", o_le, 0);
        chk("ivstall_shift", o_sh, 0);
      end
      if (c >= wr_a && c <= wr_b) begin
        chk("wrstall_win_valid", o_wv, 1);
        chk("wrstall_win_x", o_x, 0);
        chk("wrstall_win_y", o_y, 0);
        chk("wrstall_win_cg", o_g, 0);
        chk("wrstall_in_ready", o_ir, 0);
        chk("wrstall_shift", o_sh, 0);
      end
      if (o_wv && wr) begin
        acc_c.push_back(c);
        acc_x.push_back(int'(o_x));
        acc_y.push_back(int'(o_y));
        acc_g.push_back(int'(o_g));
      end
      if (o_done) begin
        done_c = c;
        done_n++;
      end
    end
    st = 1'b0;
    iv = 1'b1;
    wr = 1'b1;
  endtask

  task automatic chk_a_run(input string tag, input int c0,
                           input int c1, input int c2,
                           input int dc);
    int ec[3];
    ec[0] = c0; ec[1] = c1; ec[2] = c2;
    chk({tag, "_nwin"}, acc_c.size(), 3);
    for (int i = 0; i < acc_c.size() && i < 3; i++) begin
      chk({tag, "_win_cycle"}, acc_c[i], ec[i]);
      chk({tag, "_win_x"}, acc_x[i], i);
      chk({tag, "_win_y"}, acc_y[i], 0);
      chk({tag, "_win_cg"}, acc_g[i], 0);
    end
    chk({tag, "_le_pulses"}, le_n, 20);
    chk({tag, "_le_select_order"}, sel_bad, 0);
    chk({tag, "_le_shift_overlap"}, overlap, 0);
    chk({tag, "_done_cycle"}, done_c, dc);
    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_busy_after"}, o_busy, 0);
  endtask

  task automatic chk_b_run(input string tag);
    int ex[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int ey[8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int eg[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    chk({tag, "_nwin"}, acc_c.size(), 8);
    for (int i = 0; i < acc_c.size() && i < 8; i++) begin
      chk({tag, "_win_x"}, acc_x[i], ex[i]);
      chk({tag, "_win_y"}, acc_y[i], ey[i]);
      chk({tag, "_win_cg"}, acc_g[i], eg[i]);
    end
    chk({tag, "_le_pulses"}, le_n, 64);
    chk({tag, "_le_select_order"}, sel_bad, 0);
    chk({tag, "_le_shift_overlap"}, overlap, 0);
    chk({tag, "_done_cycle"}, done_c, 89);
    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_busy_after"}, o_busy, 0);
  endtask

  initial begin
    // reset state of both instances
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b0;
    #1 chk_idle_outs("rst_a");
    sel = 1'b1;
    #1 chk_idle_outs("rst_b");
    arst_n = 1'b1;

    // no start: stays idle
    sel = 1'b0;
    repeat (20) @(negedge clk);
    chk("nostart_busy_a", ifa.busy, 0);
    chk("nostart_busy_b", ifb.busy, 0);

    // W=5 H=3 C=4, free flowing
    run(1'b0, 32, 0, -1, 0, -1, 0);
    chk_a_run("a_free", 16, 22, 28, 29);

    // in_valid low in cycles 7..9 of the second LOAD
    run(1'b0, 36, 7, 9, 0, -1, 0);
    chk_a_run("a_ivstall", 19, 25, 31, 32);

    // win_ready low in cycles 16..25 of the first window
    run(1'b0, 42, 0, -1, 16, 25, 0);
    chk_a_run("a_wrstall", 26, 32, 38, 39);

    // both stalls combined
    run(1'b0, 46, 7, 9, 19, 28, 0);
    chk_a_run("a_both", 29, 35, 41, 42);
`ifdef IDSS_CTRL_STALL_CNT_EN
    chk("a_stall_cycles", ifa.stall_cycles, 13);
`endif

    // W=4 H=4 C=8, extra start in cycle 40 ignored
    run(1'b1, 95, 0, -1, 0, -1, 40);
    chk_b_run("b_full");

    // reset pulse mid second strip
    run(1'b1, 30, 0, -1, 0, -1, 0);
    chk("b_mid_busy", o_busy, 1);
    arst_n = 1'b0;
    #1 chk_idle_outs("b_midrst");
    @(posedge clk);
    #1 chk_idle_outs("b_midrst_held");
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("b_after_rst_busy", o_busy, 0);

    // clean rerun after reset
    run(1'b1, 95, 0, -1, 0, -1, 0);
    chk_b_run("b_rerun");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
